// File: rtl/e4m3_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : e4m3_alu_driver
// Function : Valid/ready request/response front end for the alu_e4m3 core;
//            one operation in flight, fixed ALU latency, registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module e4m3_alu_driver #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [3:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_y,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [7:0]  alu_y,
    output logic        busy,
    output logic [15:0] done_count
);

    localparam logic [3:0] c_lat    = 4'(ALU_LATENCY);
    localparam logic [3:0] c_op_add = 4'b0001;
    localparam logic [3:0] c_op_mul = 4'b0010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_y;
    logic        r_rsp_err;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [3:0]  r_alu_ctrl;
    logic        r_busy;
    logic [15:0] r_done_count;
    logic        w_legal;

    assign w_legal = (req_op == c_op_add) || (req_op == c_op_mul);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_y      <= 8'd0;
            r_rsp_err    <= 1'b0;
            r_alu_a      <= 8'd0;
            r_alu_b      <= 8'd0;
            r_alu_ctrl   <= 4'd0;
            r_busy       <= 1'b0;
            r_done_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_legal) begin
                            r_alu_a    <= req_a;
                            r_alu_b    <= req_b;
                            r_alu_ctrl <= req_op;
                            r_cnt      <= c_lat;
                            r_state    <= S_WAIT;
                        end else begin
                            r_rsp_y    <= 8'd0;
                            r_rsp_err  <= 1'b1;
                            r_alu_ctrl <= 4'd0;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // An illegal op enters RESP with valid still low; raise it one edge later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_alu_a      <= 8'd0;
                        r_alu_b      <= 8'd0;
                        r_alu_ctrl   <= 4'd0;
                        r_done_count <= r_done_count + 16'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_y      = r_rsp_y;
    assign rsp_err    = r_rsp_err;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_ctrl   = r_alu_ctrl;
    assign busy       = r_busy;
    assign done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_e4m3_alu_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_e4m3_alu_driver
// Function : Directed, table-driven bench for e4m3_alu_driver at latency 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e4m3_alu_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rv1, rr1, sv1, srdy1, serr1, busy1;
    logic [7:0]  ra1, rb1, sy1, aa1, ab1, ay1;
    logic [3:0]  rop1, ac1;
    logic [15:0] dc1;

    logic        rst3, rv3, rr3, sv3, srdy3, serr3, busy3;
    logic [7:0]  ra3, rb3, sy3, aa3, ab3, ay3;
    logic [3:0]  rop3, ac3;
    logic [15:0] dc3;

    e4m3_alu_driver #(.ALU_LATENCY(1)) dut1 (
        .clock(clk), .reset(rst1), .req_valid(rv1), .req_ready(rr1),
        .req_a(ra1), .req_b(rb1), .req_op(rop1), .rsp_valid(sv1),
        .rsp_ready(srdy1), .rsp_y(sy1), .rsp_err(serr1), .alu_a(aa1),
        .alu_b(ab1), .alu_ctrl(ac1), .alu_y(ay1), .busy(busy1), .done_count(dc1)
    );

    e4m3_alu_driver #(.ALU_LATENCY(3)) dut3 (
        .clock(clk), .reset(rst3), .req_valid(rv3), .req_ready(rr3),
        .req_a(ra3), .req_b(rb3), .req_op(rop3), .rsp_valid(sv3),
        .rsp_ready(srdy3), .rsp_y(sy3), .rsp_err(serr3), .alu_a(aa3),
        .alu_b(ab3), .alu_ctrl(ac3), .alu_y(ay3), .busy(busy3), .done_count(dc3)
    );

    // ALU stand-in: hand-computed e4m3 results for the operand sets used here.
    function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case ({c, a, b})
            20'h1_40_40: return 8'h48;
            20'h2_AC_C0: return 8'h34;
            20'h1_50_D0: return 8'h00;
            20'h1_48_D0: return 8'hC8;
            default:     return 8'hEE;
        endcase
    endfunction

    logic [7:0] p3 [3];
    always @(posedge clk) ay1 <= alu_f(ac1, aa1, ab1);
    always @(posedge clk) begin
        p3[0] <= alu_f(ac3, aa3, ab3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ay3 = p3[2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] dcount1 = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] y;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs [5];

    // Issue one request on dut1 at a negedge; rsp_ready must already be set up.
    task automatic issue1(input vec_t v, output int lat);
        logic legal;
        legal = (v.op == 4'd1) || (v.op == 4'd2);
        rv1 = 1'b1; ra1 = v.a; rb1 = v.b; rop1 = v.op;
        chk("req_ready_idle", rr1, 1);
        @(negedge clk);
        rv1 = 1'b0; ra1 = 8'hFF; rb1 = 8'hFF; rop1 = 4'hF;
        lat = 0;
        while (!sv1 && lat < 30) begin
            chk("req_ready_busy", rr1, 0);
            chk("busy_high", busy1, 1);
            chk("alu_ctrl_hold", ac1, legal ? v.op : 4'd0);
            if (legal) chk("alu_a_hold", aa1, v.a);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("rsp_y", sy1, v.y);
        chk("rsp_err", serr1, v.err);
    endtask

    task automatic run1(input vec_t v);
        int lat;
        issue1(v, lat);
        @(negedge clk);
        dcount1 = dcount1 + 16'd1;
        chk("rsp_valid_drop", sv1, 0);
        chk("req_ready_back", rr1, 1);
        chk("alu_ctrl_clear", ac1, 0);
        chk("done_count", dc1, dcount1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{8'h40, 8'h40, 4'b0001, 8'h48, 1'b0, 2};
        vecs[1] = '{8'hAC, 8'hC0, 4'b0010, 8'h34, 1'b0, 2};
        vecs[2] = '{8'h50, 8'hD0, 4'b0001, 8'h00, 1'b0, 2};
        vecs[3] = '{8'h40, 8'h40, 4'b0111, 8'h00, 1'b1, 1};
        vecs[4] = '{8'h48, 8'hD0, 4'b0001, 8'hC8, 1'b0, 2};

        rst1 = 1'b1; rv1 = 1'b0; ra1 = 8'd0; rb1 = 8'd0; rop1 = 4'd0; srdy1 = 1'b1;
        rst3 = 1'b1; rv3 = 1'b0; ra3 = 8'd0; rb3 = 8'd0; rop3 = 4'd0; srdy3 = 1'b1;
        #1;
        chk("rst_req_ready", rr1, 0);
        chk("rst_rsp_valid", sv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done_count", dc1, 0);
        chk("rst_alu_ctrl", ac1, 0);
        chk("rst_rsp_y", sy1, 0);
        @(negedge clk); @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        chk("req_ready_pre_edge", rr1, 0);
        @(negedge clk);
        chk("req_ready_first_edge", rr1, 1);

        // Back-to-back vectors, including an illegal op, with rsp_ready held high.
        for (int i = 0; i < 4; i++) run1(vecs[i]);

        // Backpressure: response held 5 cycles while a competing request is offered.
        srdy1 = 1'b0;
        issue1(vecs[4], lat);
        for (int k = 0; k < 5; k++) begin
            rv1 = 1'b1; ra1 = 8'hAC; rb1 = 8'hC0; rop1 = 4'b0010;
            chk("bp_rsp_y", sy1, 8'hC8);
            chk("bp_rsp_valid", sv1, 1);
            chk("bp_req_ready", rr1, 0);
            chk("bp_alu_ctrl", ac1, 4'b0001);
            @(negedge clk);
        end
        rv1 = 1'b0; srdy1 = 1'b1;
        chk("bp_rsp_y_last", sy1, 8'hC8);
        @(negedge clk);
        dcount1 = dcount1 + 16'd1;
        chk("bp_handshake", sv1, 0);
        chk("bp_done_count", dc1, dcount1);

        // Counter wrap: preload near the top, then complete two operations.
        force dut1.r_done_count = 16'hFFFE;
        @(negedge clk);
        release dut1.r_done_count;
        chk("preload", dc1, 16'hFFFE);
        dcount1 = 16'hFFFE;
        run1(vecs[0]);
        run1(vecs[0]);
        chk("wrap_zero", dc1, 16'h0000);

        // Asynchronous reset mid-WAIT on the latency-3 instance.
        rv3 = 1'b1; ra3 = 8'h40; rb3 = 8'h40; rop3 = 4'b0001;
        @(negedge clk);
        rv3 = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_wait_ctrl", ac3, 4'b0001);
        rst3 = 1'b1;
        #1;
        chk("ar_req_ready", rr3, 0);
        chk("ar_rsp_valid", sv3, 0);
        chk("ar_rsp_err", serr3, 0);
        chk("ar_busy", busy3, 0);
        chk("ar_rsp_y", sy3, 0);
        chk("ar_alu_a", aa3, 0);
        chk("ar_alu_b", ab3, 0);
        chk("ar_alu_ctrl", ac3, 0);
        chk("ar_done_count", dc3, 0);
        @(negedge clk); @(negedge clk);
        rst3 = 1'b0;
        chk("ar_ready_pre_edge", rr3, 0);
        @(negedge clk);
        chk("ar_ready_one_edge", rr3, 1);
        for (int k = 0; k < 6; k++) begin
            chk("ar_no_response", sv3, 0);
            @(negedge clk);
        end
        chk("ar_done_unchanged", dc3, 0);

        // Normal latency-3 operation after the aborted one.
        rv3 = 1'b1; ra3 = 8'h40; rb3 = 8'h40; rop3 = 4'b0001;
        @(negedge clk);
        rv3 = 1'b0;
        lat = 0;
        while (!sv3 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("lat3_latency", lat, 4);
        chk("lat3_rsp_y", sy3, 8'h48);
        @(negedge clk);
        chk("lat3_done_count", dc3, 1);
        chk("lat3_req_ready", rr3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
